// File: rtl/mdu_pkg.sv
// mdu_pkg: shared MU_op codes, FSM state encoding and default cycle counts for the multiply/divide unit (madd gated by MDU_MADD_EN)
package mdu_pkg;

    localparam logic [3:0] MU_MULT  = 4'd0;
    localparam logic [3:0] MU_MULTU = 4'd1;
    localparam logic [3:0] MU_DIV   = 4'd2;
    localparam logic [3:0] MU_DIVU  = 4'd3;
    localparam logic [3:0] MU_MTHI  = 4'd4;
    localparam logic [3:0] MU_MTLO  = 4'd5;
    localparam logic [3:0] MU_MFHI  = 4'd6;
    localparam logic [3:0] MU_MFLO  = 4'd7;
    localparam logic [3:0] MU_NONE  = 4'd8;
    localparam logic [3:0] MU_MADD  = 4'd9;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // True for ops that launch a multi-cycle operation when paired with Start.
    function automatic logic is_start_op(input logic [3:0] op);
`ifdef MDU_MADD_EN
        return (op <= MU_DIVU) || (op == MU_MADD);
`else
        return op <= MU_DIVU;
`endif
    endfunction

    // Divides use the longer busy window; everything else uses the multiply one.
    function automatic logic is_div_op(input logic [3:0] op);
        return (op == MU_DIV) || (op == MU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational 64-bit {hi,lo} result for mult/multu/div/divu (and madd when MDU_MADD_EN is defined)
module mdu_arith
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   hi,
    input  logic [WIDTH-1:0]   lo,
    output logic [2*WIDTH-1:0] res
);

    logic [2*WIDTH-1:0] s_prod;
    logic [2*WIDTH-1:0] u_prod;
    logic [WIDTH-1:0]   q_s;
    logic [WIDTH-1:0]   r_s;
    logic [WIDTH-1:0]   q_u;
    logic [WIDTH-1:0]   r_u;
    logic               b_zero;
    logic               s_ovf;

    // The low 2*WIDTH bits of the product of sign-extended operands equal the signed product.
    assign s_prod = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    assign u_prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    assign q_s    = $signed(a) / $signed(b);
    assign r_s    = $signed(a) % $signed(b);
    assign q_u    = a / b;
    assign r_u    = a % b;
    assign b_zero = b == '0;
    // Most-negative / -1 overflows; the architectural answer is quotient = dividend, remainder = 0.
    assign s_ovf  = (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);

    // Select the result; a zero divisor hands back the current HI/LO so the commit is a no-op.
    always_comb begin
        res = {hi, lo};
        if (op == MU_MULT)
            res = s_prod;
        else if (op == MU_MULTU)
            res = u_prod;
        else if (op == MU_DIV)
            res = b_zero ? {hi, lo} : s_ovf ? {{WIDTH{1'b0}}, a} : {r_s, q_s};
        else if (op == MU_DIVU)
            res = b_zero ? {hi, lo} : {r_u, q_u};
`ifdef MDU_MADD_EN
        else if (op == MU_MADD)
            res = {hi, lo} + s_prod;
`endif
    end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: execute-stage multiply/divide unit with HI/LO registers, busy handshake and combinational mfhi/mflo (madd via MDU_MADD_EN)
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       MU_op,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic [WIDTH-1:0] MU_result
);

    localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    state_t             state;
    logic [CW-1:0]      counter;
    logic [WIDTH-1:0]   hi_n;
    logic [WIDTH-1:0]   lo_n;
    logic [2*WIDTH-1:0] res;

    mdu_arith #(.WIDTH(WIDTH)) u_arith (
        .op  (MU_op),
        .a   (A),
        .b   (B),
        .hi  (HI),
        .lo  (LO),
        .res (res)
    );

    // Read-out is never gated by busy; the stall unit holds mfhi/mflo back instead.
    assign MU_result = (MU_op == MU_MFHI) ? HI : (MU_op == MU_MFLO) ? LO : '0;

    // Issue captures the full result into shadows; HI/LO only move at the final busy edge or on mt*.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            counter <= '0;
            busy    <= 1'b0;
            HI      <= '0;
            LO      <= '0;
            hi_n    <= '0;
            lo_n    <= '0;
        end else if (state == ST_IDLE) begin
            if (Start && is_start_op(MU_op)) begin
                {hi_n, lo_n} <= res;
                counter      <= is_div_op(MU_op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                busy         <= 1'b1;
                state        <= ST_BUSY;
            end else if (MU_op == MU_MTHI) begin
                HI <= A;
            end else if (MU_op == MU_MTLO) begin
                LO <= A;
            end
        end else begin
            counter <= counter - 1'b1;
            if (counter == CW'(1)) begin
                HI    <= hi_n;
                LO    <= lo_n;
                busy  <= 1'b0;
                state <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench for mult_div_unit covering timing, arithmetic corners, mt*/mf*, ignored starts and async reset
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  MU_op = 4'd8;
    logic        Start = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MU_result;

    int checks = 0;
    int errors = 0;
    logic [63:0] sb[$];

    mult_div_unit dut (
        .clk       (clk),
        .reset     (reset),
        .MU_op     (MU_op),
        .Start     (Start),
        .A         (A),
        .B         (B),
        .busy      (busy),
        .HI        (HI),
        .LO        (LO),
        .MU_result (MU_result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int n, input int inj);
        logic [63:0] pre;
        logic [63:0] want;
        int cycles;
        pre = {HI, LO};
        sb.push_back(exp);
        MU_op = op;
        Start = 1'b1;
        A = a;
        B = b;
        tick();
        Start = 1'b0;
        MU_op = 4'd8;
        chk({tag, "_busy_rise"}, 64'(busy), 64'd1);
        cycles = 0;
        while (busy && cycles < 200) begin
            if (cycles + 1 == inj) begin
                Start = 1'b1;
                MU_op = 4'd0;
                A = 32'd3;
                B = 32'd4;
            end
            tick();
            cycles++;
            Start = 1'b0;
            MU_op = 4'd8;
            if (busy) chk({tag, "_hold"}, {HI, LO}, pre);
        end
        chk({tag, "_latency"}, 64'(cycles), 64'(n));
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            want = sb.pop_front();
            chk({tag, "_hilo"}, {HI, LO}, want);
        end
    endtask

    task automatic mt(input logic [3:0] op, input logic [31:0] a);
        MU_op = op;
        A = a;
        tick();
        MU_op = 4'd8;
    endtask

    initial begin
        #12;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_hilo", {HI, LO}, 64'd0);
        chk("rst_mures", 64'(MU_result), 64'd0);
        reset = 1'b1;
        tick();

        run_op("mult",  4'd0, 32'hFFFFFFFF, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFE}, 5, 0);
        run_op("multu", 4'd1, 32'hFFFFFFFF, 32'd2, {32'h00000001, 32'hFFFFFFFE}, 5, 0);
        run_op("div",   4'd2, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 10, 0);
        run_op("divu",  4'd3, 32'hFFFFFFF9, 32'd2, {32'h00000001, 32'h7FFFFFFC}, 10, 0);

        mt(4'd4, 32'h12345678);
        chk("mthi_hi", 64'(HI), 64'h12345678);
        chk("mthi_busy", 64'(busy), 64'd0);
        MU_op = 4'd6;
        #1;
        chk("mfhi", 64'(MU_result), 64'h12345678);
        MU_op = 4'd7;
        #1;
        chk("mflo", 64'(MU_result), 64'h7FFFFFFC);
        MU_op = 4'd8;
        #1;
        chk("mfnone", 64'(MU_result), 64'd0);

        mt(4'd5, 32'h0000AAAA);
        chk("mtlo_lo", 64'(LO), 64'h0000AAAA);
        run_op("div0", 4'd2, 32'd100, 32'd0, {32'h12345678, 32'h0000AAAA}, 10, 0);
        run_op("divovf", 4'd2, 32'h80000000, 32'hFFFFFFFF, {32'h00000000, 32'h80000000}, 10, 0);
        run_op("divinj", 4'd2, 32'd100, 32'd7, {32'd2, 32'd14}, 10, 3);

        Start = 1'b1;
        MU_op = 4'd8;
        tick();
        Start = 1'b0;
        chk("start_none", {63'd0, busy}, 64'd0);

`ifdef MDU_MADD_EN
        mt(4'd4, 32'h0);
        mt(4'd5, 32'hFFFFFFFF);
        run_op("madd", 4'd9, 32'd1, 32'd1, {32'h00000001, 32'h00000000}, 5, 0);
`else
        Start = 1'b1;
        MU_op = 4'd9;
        A = 32'd1;
        B = 32'd1;
        tick();
        Start = 1'b0;
        MU_op = 4'd8;
        chk("madd_off_busy", 64'(busy), 64'd0);
        chk("madd_off_hilo", {HI, LO}, {32'd2, 32'd14});
`endif

        MU_op = 4'd2;
        Start = 1'b1;
        A = 32'd50;
        B = 32'd3;
        tick();
        Start = 1'b0;
        MU_op = 4'd8;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_hilo", {HI, LO}, 64'd0);
        tick();
        reset = 1'b1;
        repeat (12) tick();
        chk("arst_after_busy", 64'(busy), 64'd0);
        chk("arst_after_hilo", {HI, LO}, 64'd0);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
